// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - coin/change codes, dispenser states and price lookup for the vending ledger
package vending_pkg;

    localparam logic [1:0] COIN_1  = 2'd0;
    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_10 = 2'd2;
    localparam logic [1:0] COIN_20 = 2'd3;

    localparam logic [1:0] CHG_1  = 2'd0;
    localparam logic [1:0] CHG_5  = 2'd1;
    localparam logic [1:0] CHG_10 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_GAP  = 2'd2
    } disp_state_e;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 8'd1;
            COIN_5:  return 8'd5;
            COIN_10: return 8'd10;
            default: return 8'd20;
        endcase
    endfunction

    function automatic logic [7:0] change_value(input logic [1:0] code);
        case (code)
            CHG_10:  return 8'd10;
            CHG_5:   return 8'd5;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] price_of(input logic [1:0] item,
                                            input logic [7:0] p0, input logic [7:0] p1,
                                            input logic [7:0] p2, input logic [7:0] p3);
        case (item)
            2'd0:    return p0;
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

endpackage

// File: rtl/vending_change_disp.sv
// rtl/vending_change_disp.sv - paced change dispenser: greedy 10/5/1 ejection with an idle gap between coins
module vending_change_disp
    import vending_pkg::*;
#(
    parameter int DISP_GAP = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       charge_st_flag,
    input  logic       credit_in,
    input  logic [7:0] balance,
    output logic [7:0] debit,
    output logic       change_pulse,
    output logic [1:0] change_coin,
    output logic       change_busy,
    output logic       change_done
);

    localparam int GW = (DISP_GAP < 1) ? 1 : $clog2(DISP_GAP + 1);

    disp_state_e   state_q;
    logic [GW-1:0] gap_cnt_q;
    logic          done_q;
    logic [1:0]    coin_sel;
    logic          ejecting;

    always_comb begin
        coin_sel = CHG_1;
        if (balance >= 8'd10)
            coin_sel = CHG_10;
        else if (balance >= 8'd5)
            coin_sel = CHG_5;
    end

    assign ejecting     = (state_q == ST_DISP) && (balance != 8'd0);
    assign change_pulse = ejecting;
    assign change_coin  = ejecting ? coin_sel : 2'd0;
    assign debit        = ejecting ? change_value(coin_sel) : 8'd0;
    assign change_busy  = (state_q != ST_IDLE);
    assign change_done  = done_q;

    // A refund of an already-empty balance reports done on entry to DISP; the
    // following empty DISP then leaves without a second done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (charge_st_flag) begin
                        state_q <= ST_DISP;
                        done_q  <= (balance == 8'd0) && !credit_in;
                    end
                end
                ST_DISP: begin
                    if (balance != 8'd0) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= '0;
                    end else if (!credit_in) begin
                        state_q <= ST_IDLE;
                        done_q  <= !done_q;
                    end
                end
                ST_GAP: begin
                    if (32'(gap_cnt_q) + 1 >= DISP_GAP)
                        state_q <= ST_DISP;
                    else
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vending_ledger.sv
// rtl/vending_ledger.sv - vending balance register arbitrating coin credit, purchase debit and change debit
module vending_ledger
    import vending_pkg::*;
#(
    parameter int DISP_GAP = 100,
    parameter int PRICE0   = 3,
    parameter int PRICE1   = 5,
    parameter int PRICE2   = 8,
    parameter int PRICE3   = 12,
    parameter int BAL_MAX  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] item_sel,
    input  logic [1:0] coin_val,
    input  logic       coin_fn_flag,
    input  logic       pay_st_flag,
    input  logic       charge_st_flag,
    output logic       nonenough_flag,
    output logic [7:0] balance,
    output logic       paid_flag,
    output logic [1:0] paid_item,
    output logic       pay_fail_flag,
    output logic       coin_reject_flag,
    output logic       change_pulse,
    output logic [1:0] change_coin,
    output logic       change_busy,
    output logic       change_done
);

    logic [7:0] balance_q, balance_d;
    logic       paid_q, paid_d;
    logic [1:0] paid_item_q, paid_item_d;
    logic       fail_q, fail_d;
    logic       rej_q, rej_d;
    logic [7:0] price;
    logic [7:0] debit;
    logic [7:0] post_pay;
    logic [8:0] sum;
    logic       pay_ok;
    logic       coin_ok;

    assign price          = price_of(item_sel, 8'(PRICE0), 8'(PRICE1), 8'(PRICE2), 8'(PRICE3));
    assign nonenough_flag = (balance_q < price);

    // Pay is judged on the pre-coin balance; the coin's overflow test then
    // sees the balance after the purchase or change debit.
    always_comb begin
        pay_ok      = pay_st_flag && !nonenough_flag && !change_busy;
        post_pay    = balance_q - (pay_ok ? price : 8'd0) - debit;
        sum         = {1'b0, post_pay} + {1'b0, coin_value(coin_val)};
        coin_ok     = coin_fn_flag && (sum <= 9'(BAL_MAX));
        balance_d   = coin_ok ? sum[7:0] : post_pay;
        paid_d      = pay_ok;
        fail_d      = pay_st_flag && !pay_ok;
        rej_d       = coin_fn_flag && !coin_ok;
        paid_item_d = pay_ok ? item_sel : paid_item_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            balance_q   <= 8'd0;
            paid_q      <= 1'b0;
            paid_item_q <= 2'd0;
            fail_q      <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            balance_q   <= balance_d;
            paid_q      <= paid_d;
            paid_item_q <= paid_item_d;
            fail_q      <= fail_d;
            rej_q       <= rej_d;
        end
    end

    assign balance          = balance_q;
    assign paid_flag        = paid_q;
    assign paid_item        = paid_item_q;
    assign pay_fail_flag    = fail_q;
    assign coin_reject_flag = rej_q;

    vending_change_disp #(
        .DISP_GAP(DISP_GAP)
    ) u_change_disp (
        .clk           (clk),
        .rst_n         (rst_n),
        .charge_st_flag(charge_st_flag),
        .credit_in     (coin_ok),
        .balance       (balance_q),
        .debit         (debit),
        .change_pulse  (change_pulse),
        .change_coin   (change_coin),
        .change_busy   (change_busy),
        .change_done   (change_done)
    );

endmodule

// File: tb/tb_vending_ledger.sv
// tb/tb_vending_ledger.sv - scoreboard bench for vending_ledger with a short dispense gap
module tb_vending_ledger;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] item_sel;
    logic [1:0] coin_val;
    logic       coin_fn_flag;
    logic       pay_st_flag;
    logic       charge_st_flag;
    logic       nonenough_flag;
    logic [7:0] balance;
    logic       paid_flag;
    logic [1:0] paid_item;
    logic       pay_fail_flag;
    logic       coin_reject_flag;
    logic       change_pulse;
    logic [1:0] change_coin;
    logic       change_busy;
    logic       change_done;

    typedef struct {
        logic [1:0] coin;
        int         t;
    } exp_chg_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] model_bal = 8'd0;
    logic [7:0] exp_bal[$];
    logic       exp_rej[$];
    exp_chg_t   exp_chg[$];

    vending_ledger #(
        .DISP_GAP(GAP), .PRICE0(3), .PRICE1(5), .PRICE2(8), .PRICE3(12), .BAL_MAX(255)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .item_sel        (item_sel),
        .coin_val        (coin_val),
        .coin_fn_flag    (coin_fn_flag),
        .pay_st_flag     (pay_st_flag),
        .charge_st_flag  (charge_st_flag),
        .nonenough_flag  (nonenough_flag),
        .balance         (balance),
        .paid_flag       (paid_flag),
        .paid_item       (paid_item),
        .pay_fail_flag   (pay_fail_flag),
        .coin_reject_flag(coin_reject_flag),
        .change_pulse    (change_pulse),
        .change_coin     (change_coin),
        .change_busy     (change_busy),
        .change_done     (change_done)
    );

    always #5 clk = ~clk;

    function automatic int cval(input logic [1:0] code);
        case (code)
            2'd0: return 1;
            2'd1: return 5;
            2'd2: return 10;
            default: return 20;
        endcase
    endfunction

    function automatic int price_tb(input logic [1:0] item);
        case (item)
            2'd0: return 3;
            2'd1: return 5;
            2'd2: return 8;
            default: return 12;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coin(input logic [1:0] code);
        int nb;
        nb = int'(model_bal) + cval(code);
        coin_val     = code;
        coin_fn_flag = 1'b1;
        if (nb <= 255) model_bal = 8'(nb);
        exp_bal.push_back(model_bal);
        exp_rej.push_back(nb > 255);
        step;
        coin_fn_flag = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        step;
        checks++;
        if (balance !== 8'd0 || paid_flag !== 1'b0 || pay_fail_flag !== 1'b0 || coin_reject_flag !== 1'b0)
            begin errors++; $display("FAIL reset_ledger bal=%0d paid=%b fail=%b rej=%b exp 0", balance, paid_flag, pay_fail_flag, coin_reject_flag); end
        checks++;
        if (change_busy !== 1'b0 || change_pulse !== 1'b0 || change_done !== 1'b0 || paid_item !== 2'd0 || change_coin !== 2'd0)
            begin errors++; $display("FAIL reset_disp busy=%b pulse=%b done=%b item=%0d coin=%0d exp 0", change_busy, change_pulse, change_done, paid_item, change_coin); end
        rst_n = 1'b1;
        model_bal = 8'd0;
        step;
    endtask

    task automatic test_coins;
        logic [1:0] codes [3] = '{2'd1, 2'd2, 2'd0};
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            drive_coin(codes[i]);
            e = exp_bal.pop_front();
            void'(exp_rej.pop_front());
            checks++;
            if (balance !== e) begin errors++; $display("FAIL coin_accum[%0d] balance=%0d exp %0d", i, balance, e); end
        end
    endtask

    task automatic test_refund;
        int b, k, done_t;
        logic done_seen;
        logic [7:0] e;
        exp_chg_t x;
        drive_coin(2'd0);
        e = exp_bal.pop_front();
        void'(exp_rej.pop_front());
        checks++;
        if (balance !== e) begin errors++; $display("FAIL refund_setup balance=%0d exp %0d", balance, e); end
        b = int'(model_bal);
        k = 0;
        while (b > 0) begin
            x.coin = (b >= 10) ? 2'd2 : ((b >= 5) ? 2'd1 : 2'd0);
            x.t    = 1 + k * (GAP + 1);
            b     -= cval(x.coin);
            exp_chg.push_back(x);
            k++;
        end
        done_t = (k == 0) ? 1 : k * (GAP + 1) + 2;
        charge_st_flag = 1'b1;
        step;
        charge_st_flag = 1'b0;
        checks++;
        if (change_busy !== 1'b1) begin errors++; $display("FAIL refund_busy_rise busy=%b exp 1", change_busy); end
        done_seen = 1'b0;
        for (int t = 1; t <= 60 && !done_seen; t++) begin
            if (change_pulse === 1'b1) begin
                checks++;
                if (exp_chg.size() == 0) begin
                    errors++; $display("FAIL refund_extra_pulse t=%0d coin=%0d exp no pulse", t, change_coin);
                end else begin
                    x = exp_chg.pop_front();
                    if (change_coin !== x.coin || t != x.t) begin
                        errors++; $display("FAIL refund_pulse coin=%0d t=%0d exp coin=%0d t=%0d", change_coin, t, x.coin, x.t);
                    end
                end
            end
            if (change_done === 1'b1) begin
                done_seen = 1'b1;
                checks++;
                if (t != done_t || change_busy !== 1'b0)
                    begin errors++; $display("FAIL refund_done t=%0d busy=%b exp t=%0d busy=0", t, change_busy, done_t); end
            end else begin
                step;
            end
        end
        checks++;
        if (!done_seen) begin errors++; $display("FAIL refund_timeout done=0 exp done by t=%0d", done_t); end
        checks++;
        if (exp_chg.size() != 0 || balance !== 8'd0)
            begin errors++; $display("FAIL refund_end left=%0d balance=%0d exp 0 and 0", exp_chg.size(), balance); end
        model_bal = 8'd0;
        step;
    endtask

    task automatic test_short_balance;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            drive_coin(2'd0);
            e = exp_bal.pop_front();
            void'(exp_rej.pop_front());
        end
        checks++;
        if (balance !== e) begin errors++; $display("FAIL short_setup balance=%0d exp %0d", balance, e); end
        item_sel = 2'd1;
        #1;
        checks++;
        if (nonenough_flag !== (int'(model_bal) < price_tb(2'd1)))
            begin errors++; $display("FAIL short_nonenough got=%b exp 1", nonenough_flag); end
        pay_st_flag = 1'b1;
        step;
        pay_st_flag = 1'b0;
        checks++;
        if (pay_fail_flag !== 1'b1 || paid_flag !== 1'b0 || balance !== model_bal)
            begin errors++; $display("FAIL short_pay fail=%b paid=%b bal=%0d exp 1 0 %0d", pay_fail_flag, paid_flag, balance, model_bal); end
    endtask

    task automatic test_coin_and_pay;
        logic [7:0] e;
        drive_coin(2'd0);
        e = exp_bal.pop_front();
        void'(exp_rej.pop_front());
        item_sel = 2'd1;
        #1;
        checks++;
        if (balance !== e || nonenough_flag !== 1'b0)
            begin errors++; $display("FAIL cp_setup bal=%0d nonenough=%b exp %0d 0", balance, nonenough_flag, e); end
        model_bal = 8'(int'(model_bal) - price_tb(2'd1) + cval(2'd2));
        coin_val = 2'd2; coin_fn_flag = 1'b1; pay_st_flag = 1'b1;
        step;
        coin_fn_flag = 1'b0; pay_st_flag = 1'b0;
        checks++;
        if (paid_flag !== 1'b1 || paid_item !== 2'd1 || balance !== model_bal || pay_fail_flag !== 1'b0)
            begin errors++; $display("FAIL coin_and_pay paid=%b item=%0d bal=%0d fail=%b exp 1 1 %0d 0", paid_flag, paid_item, balance, pay_fail_flag, model_bal); end
        step;
        checks++;
        if (paid_flag !== 1'b0 || paid_item !== 2'd1)
            begin errors++; $display("FAIL paid_pulse_width paid=%b item=%0d exp 0 1", paid_flag, paid_item); end
    endtask

    task automatic test_overflow;
        logic [7:0] e;
        logic       r;
        logic [1:0] tail [3] = '{2'd2, 2'd1, 2'd0};
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        model_bal = 8'd0;
        step;
        for (int i = 0; i < 13; i++) begin
            drive_coin(i < 12 ? 2'd3 : 2'd2);
            e = exp_bal.pop_front();
            void'(exp_rej.pop_front());
        end
        checks++;
        if (balance !== e) begin errors++; $display("FAIL ovf_setup balance=%0d exp %0d", balance, e); end
        for (int i = 0; i < 3; i++) begin
            drive_coin(tail[i]);
            e = exp_bal.pop_front();
            r = exp_rej.pop_front();
            checks++;
            if (balance !== e || coin_reject_flag !== r)
                begin errors++; $display("FAIL overflow[%0d] bal=%0d rej=%b exp %0d %b", i, balance, coin_reject_flag, e, r); end
        end
    endtask

    task automatic test_reset_mid_refund;
        charge_st_flag = 1'b1;
        step;
        charge_st_flag = 1'b0;
        checks++;
        if (change_pulse !== 1'b1 || change_coin !== 2'd2)
            begin errors++; $display("FAIL mid_first_pulse pulse=%b coin=%0d exp 1 2", change_pulse, change_coin); end
        step;
        rst_n = 1'b0;
        #1;
        checks++;
        if (balance !== 8'd0 || change_busy !== 1'b0 || change_pulse !== 1'b0 || change_done !== 1'b0 || change_coin !== 2'd0)
            begin errors++; $display("FAIL mid_reset bal=%0d busy=%b pulse=%b done=%b coin=%0d exp all 0", balance, change_busy, change_pulse, change_done, change_coin); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_bal = 8'd0;
        step;
        charge_st_flag = 1'b1;
        step;
        charge_st_flag = 1'b0;
        checks++;
        if (change_done !== 1'b1 || change_busy !== 1'b1 || change_pulse !== 1'b0)
            begin errors++; $display("FAIL zero_refund_t1 done=%b busy=%b pulse=%b exp 1 1 0", change_done, change_busy, change_pulse); end
        step;
        checks++;
        if (change_done !== 1'b0 || change_busy !== 1'b0 || balance !== 8'd0)
            begin errors++; $display("FAIL zero_refund_t2 done=%b busy=%b bal=%0d exp 0 0 0", change_done, change_busy, balance); end
    endtask

    initial begin
        rst_n = 1'b0; item_sel = 2'd0; coin_val = 2'd0;
        coin_fn_flag = 1'b0; pay_st_flag = 1'b0; charge_st_flag = 1'b0;
        test_reset;
        test_coins;
        test_refund;
        test_short_balance;
        test_coin_and_pay;
        test_overflow;
        test_reset_mid_refund;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1);
    end

endmodule
